rotor_step_driver: RTL and testbench
====================================

ROTOR_STEP_DRIVER -- requirements
Module: rotor_step_driver

Interface
REQ-001 Parameter STEPS_PER_45, default 25: motor steps per 45-degree rotor segment (range 1..255).
REQ-002 Parameter STEP_HIGH_CYC, default 50: step pulse high width in clk cycles (range 1..STEP_PERIOD_CYC-1).
REQ-003 Parameter STEP_PERIOD_CYC, default 500: step pulse period in clk cycles (range 2..65535).
REQ-004 Parameter DIR_SETUP_CYC, default 10: cycles dir is held stable before the first step edge (range 1..255).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 cmd_valid  in  1  angle command present.
REQ-008 cmd_angle  in  8  angle code from the rotor angle table.
REQ-009 cmd_ready  out  1  driver can accept a command.
REQ-010 stop_req  in  1  level request to abort the current move.
REQ-011 step  out  1  step pulse to motor driver.
REQ-012 dir  out  1  1 = positive (CW, +45 direction), 0 = negative.
REQ-013 busy  out  1  move in progress.
REQ-014 done  out  1  one-cycle pulse at command completion.
REQ-015 cmd_err  out  1  one-cycle pulse with done for an unrecognised code.
REQ-016 cmd_abort  out  1  one-cycle pulse with done for a stop_req-terminated move.
REQ-017 rotor_state  out  8  {5'b11000, pos[2:0]}, pos = rotor position index 0..7 in 45-degree units.

Function
REQ-018 Code decode: 8'hF7 = -2 segments; 8'hF6 = -1; 8'hF5 = +1; 8'hF4 and 8'h00 = 0 segments; every other code = error, 0 segments.
REQ-019 Transfer occurs on a cycle with cmd_valid & cmd_ready; cmd_ready is high only in IDLE and not in reset; cmd_angle is sampled only on transfer.
REQ-020 FSM states: IDLE, SETUP, PULSE_HI, PULSE_LO, DONE.
REQ-021 IDLE -> DONE on transfer of a zero-segment or error code; IDLE -> SETUP on transfer of a non-zero code.
REQ-022 On entry to SETUP, dir updates to the command sign; SETUP lasts exactly DIR_SETUP_CYC cycles, then goes to PULSE_HI.
REQ-023 step is high exactly in PULSE_HI (STEP_HIGH_CYC cycles) and low in PULSE_LO (STEP_PERIOD_CYC-STEP_HIGH_CYC cycles).
REQ-024 Total pulses = |segments| x STEPS_PER_45; after the last PULSE_LO, go to DONE; otherwise go back to PULSE_HI.
REQ-025 pos changes by +/-1 modulo 8 (7+1 -> 0, 0-1 -> 7) in the cycle after each completed STEPS_PER_45-pulse group.
REQ-026 DONE lasts one cycle: done = 1; cmd_err/cmd_abort asserted as applicable; then IDLE.
REQ-027 stop_req sampled high in SETUP -> DONE next cycle, no pulses. Sampled high in PULSE_HI or PULSE_LO -> current pulse finishes its PULSE_LO, then DONE with cmd_abort; pos reflects completed groups only.
REQ-028 stop_req in IDLE has no effect and never blocks cmd_ready.
REQ-029 busy = 1 in SETUP, PULSE_HI, PULSE_LO, DONE.
REQ-030 Timing counters and the pulse counter are sized for the parameter maxima; no overflow for legal parameters.

Reset
REQ-031 rst_n low at a clock edge, in any state including mid-pulse: FSM -> IDLE, step = 0, dir = 0, busy = 0, done = cmd_err = cmd_abort = 0, pos = 0 (rotor_state = 8'hC0), all counters 0.
REQ-032 cmd_ready = 1 on the first cycle after rst_n is released.

Structure
REQ-033 Angle code constants (F7/F6/F5/F4/00), the state enum and the rotor_state prefix go in a shared rotor package, also used by the angle table.
REQ-034 One sub-module, rotor_angle_decode: combinational code -> {signed segment count, error}.

Verification (STEPS_PER_45 = 2, STEP_HIGH_CYC = 2, STEP_PERIOD_CYC = 5, DIR_SETUP_CYC = 1)
REQ-035 After reset, cmd 8'hF5 -> dir = 1; 2 step pulses (2 high / 3 low); done 1 + 1 + 10 cycles after transfer; rotor_state 8'hC0 -> 8'hC1.
REQ-036 From pos 0, cmd 8'hF7 -> dir = 0; 4 pulses; pos 0 -> 7 -> 6; rotor_state ends at 8'hC6; no cmd_err.
REQ-037 cmd 8'hF4, then 8'h3C -> no step pulses; done one cycle after each transfer; cmd_err only for 8'h3C; pos unchanged.
REQ-038 cmd 8'hF6, stop_req raised during the first PULSE_HI -> exactly 1 pulse; done with cmd_abort; pos unchanged.
REQ-039 rst_n low during a PULSE_HI of an 8'hF5 move -> next cycle step = 0, busy = 0, rotor_state = 8'hC0, cmd_ready = 1 after release.
REQ-040 cmd_valid held high with back-to-back commands -> each accepted only in IDLE; no transfer while busy.

Source files
------------

// File: rtl/rotor_step_driver_pkg.sv
// Shared definitions for the rotor step driver and the rotor angle table.
//   - angle code constants understood by the driver
//   - FSM state enum (also exported on the driver's debug port)
//   - rotor_state prefix and the signed segment-count type
package rotor_step_driver_pkg;

  // Angle codes from the rotor angle table
  localparam logic [7:0] ANGLE_M2   = 8'hF7;  // -2 segments (-90 deg)
  localparam logic [7:0] ANGLE_M1   = 8'hF6;  // -1 segment  (-45 deg)
  localparam logic [7:0] ANGLE_P1   = 8'hF5;  // +1 segment  (+45 deg)
  localparam logic [7:0] ANGLE_ZERO = 8'hF4;  // hold position
  localparam logic [7:0] ANGLE_NULL = 8'h00;  // hold position

  // Upper bits of rotor_state; the low three bits carry the position index
  localparam logic [4:0] ROTOR_STATE_PREFIX = 5'b11000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_PULSE_LO = 3'd3,
    ST_DONE     = 3'd4
  } drv_state_e;

  // Signed segment count, range -2..+1
  typedef logic signed [2:0] seg_t;

endpackage

// File: rtl/rotor_angle_decode.sv
// Combinational angle-code decoder.
// Ports:
//   i_code  in  8  angle code
//   o_seg   out 3  signed segment count (-2..+1)
//   o_err   out 1  code is not recognised (segment count forced to 0)
module rotor_angle_decode
  import rotor_step_driver_pkg::*;
(
  input  logic [7:0] i_code,
  output seg_t       o_seg,
  output logic       o_err
);

  always_comb begin
    o_seg = '0;
    o_err = 1'b0;
    case (i_code)
      ANGLE_M2:               o_seg = -3'sd2;
      ANGLE_M1:               o_seg = -3'sd1;
      ANGLE_P1:               o_seg = 3'sd1;
      ANGLE_ZERO, ANGLE_NULL: o_seg = 3'sd0;
      default:                o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rotor_step_driver.sv
// Rotor step driver: accepts an angle command, turns it into a burst of step
// pulses (STEPS_PER_45 per 45-degree segment) with a direction setup time,
// tracks the rotor position in 45-degree units and supports a stop request.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE outside reset, and
// cmd_angle is only looked at on that transfer edge.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_angle   command in;  cmd_ready out
//   stop_req              level abort request
//   step, dir             motor driver outputs
//   busy, done            move status; done pulses one cycle at completion
//   cmd_err, cmd_abort    completion qualifiers, valid with done
//   rotor_state           {5'b11000, pos[2:0]}
//   dbg_state             current FSM state
module rotor_step_driver
  import rotor_step_driver_pkg::*;
#(
  parameter int STEPS_PER_45    = 25,
  parameter int STEP_HIGH_CYC   = 50,
  parameter int STEP_PERIOD_CYC = 500,
  parameter int DIR_SETUP_CYC   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_angle,
  output logic       cmd_ready,
  input  logic       stop_req,
  output logic       step,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic       cmd_abort,
  output logic [7:0] rotor_state,
  output drv_state_e dbg_state
);

  // Terminal counts; timing counter is 16 bits to cover a 65535-cycle period
  localparam logic [15:0] L_SETUP_LAST = 16'(DIR_SETUP_CYC - 1);
  localparam logic [15:0] L_HI_LAST    = 16'(STEP_HIGH_CYC - 1);
  localparam logic [15:0] L_LO_LAST    = 16'(STEP_PERIOD_CYC - STEP_HIGH_CYC - 1);
  localparam logic [7:0]  L_GRP_LAST   = 8'(STEPS_PER_45 - 1);

  drv_state_e  r_state;
  drv_state_e  w_next;
  logic [15:0] r_tcnt;       // cycles spent in the current timed state
  logic [7:0]  r_grp_cnt;    // pulses completed in the current 45-degree group
  logic [1:0]  r_seg_left;   // groups still to run, including the current one
  logic [2:0]  r_pos;
  logic        r_dir;
  logic        r_stop;       // stop seen during the pulse train
  logic        r_err;
  logic        r_abort;

  seg_t        w_seg;
  logic        w_dec_err;
  logic [1:0]  w_seg_mag;
  logic        w_xfer;
  logic        w_tc_end;
  logic        w_grp_end;
  logic        w_last_pulse;

  rotor_angle_decode u_decode (
    .i_code (cmd_angle),
    .o_seg  (w_seg),
    .o_err  (w_dec_err)
  );

  assign w_seg_mag    = w_seg[2] ? 2'(-w_seg) : w_seg[1:0];
  assign w_xfer       = cmd_valid & cmd_ready;
  assign w_grp_end    = (r_grp_cnt == L_GRP_LAST);
  assign w_last_pulse = w_grp_end && (r_seg_left == 2'd1);

  always_comb begin
    w_tc_end = 1'b0;
    case (r_state)
      ST_SETUP:    w_tc_end = (r_tcnt == L_SETUP_LAST);
      ST_PULSE_HI: w_tc_end = (r_tcnt == L_HI_LAST);
      ST_PULSE_LO: w_tc_end = (r_tcnt == L_LO_LAST);
      default:     w_tc_end = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_next = (w_seg == 3'sd0) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: begin
        if (stop_req)      w_next = ST_DONE;
        else if (w_tc_end) w_next = ST_PULSE_HI;
      end
      ST_PULSE_HI: begin
        if (w_tc_end) w_next = ST_PULSE_LO;
      end
      ST_PULSE_LO: begin
        // A stop lets the current pulse finish its low phase first
        if (w_tc_end) w_next = (w_last_pulse || r_stop || stop_req) ? ST_DONE : ST_PULSE_HI;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tcnt     <= '0;
      r_grp_cnt  <= '0;
      r_seg_left <= '0;
      r_pos      <= '0;
      r_dir      <= 1'b0;
      r_stop     <= 1'b0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if ((w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_DONE)) r_tcnt <= '0;
      else                                                                   r_tcnt <= r_tcnt + 16'd1;

      case (r_state)
        ST_IDLE: begin
          r_stop <= 1'b0;
          if (w_xfer) begin
            r_err      <= w_dec_err;
            r_abort    <= 1'b0;
            r_grp_cnt  <= '0;
            r_seg_left <= w_seg_mag;
            if (w_seg != 3'sd0) r_dir <= ~w_seg[2];
          end
        end
        ST_SETUP: begin
          if (stop_req) r_abort <= 1'b1;
        end
        ST_PULSE_HI: begin
          if (stop_req) r_stop <= 1'b1;
        end
        ST_PULSE_LO: begin
          if (stop_req) r_stop <= 1'b1;
          if (w_tc_end) begin
            if (w_grp_end) begin
              r_grp_cnt  <= '0;
              r_seg_left <= r_seg_left - 2'd1;
              r_pos      <= r_dir ? (r_pos + 3'd1) : (r_pos - 3'd1);
            end else begin
              r_grp_cnt  <= r_grp_cnt + 8'd1;
            end
            // Ending on the natural last pulse is a normal completion
            if ((r_stop || stop_req) && !w_last_pulse) r_abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = rst_n && (r_state == ST_IDLE);
  assign step        = (r_state == ST_PULSE_HI);
  assign dir         = r_dir;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign cmd_err     = done & r_err;
  assign cmd_abort   = done & r_abort;
  assign rotor_state = {ROTOR_STATE_PREFIX, r_pos};
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rotor_step_driver.sv
module tb_rotor_step_driver;
  import rotor_step_driver_pkg::*;

  localparam int STEPS  = 2;
  localparam int HIGH   = 2;
  localparam int PERIOD = 5;
  localparam int DSETUP = 1;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_angle;
  logic       cmd_ready;
  logic       stop_req;
  logic       step;
  logic       dir;
  logic       busy;
  logic       done;
  logic       cmd_err;
  logic       cmd_abort;
  logic [7:0] rotor_state;
  drv_state_e dbg_state;

  always #5 clk = ~clk;

  rotor_step_driver #(
    .STEPS_PER_45    (STEPS),
    .STEP_HIGH_CYC   (HIGH),
    .STEP_PERIOD_CYC (PERIOD),
    .DIR_SETUP_CYC   (DSETUP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_angle   (cmd_angle),
    .cmd_ready   (cmd_ready),
    .stop_req    (stop_req),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .done        (done),
    .cmd_err     (cmd_err),
    .cmd_abort   (cmd_abort),
    .rotor_state (rotor_state),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int pulses;
    int done_k;      // cycle index (transfer cycle = 0) at which done is seen
    int hi_cyc;
    int busy_cyc;
    int err;
    int abort;
    int dir;
    int st;
    int ready_viol;  // cycles with busy and cmd_ready both high
  } res_t;

  typedef struct {
    logic [7:0] code;
    int         stop_c;
    int         pulses;
    int         done_k;
    int         err;
    int         abort;
    int         st;
    int         dir;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t r, input res_t e);
    chk({tag, ".done_k"},   r.done_k,     e.done_k);
    chk({tag, ".pulses"},   r.pulses,     e.pulses);
    chk({tag, ".hi_cyc"},   r.hi_cyc,     e.hi_cyc);
    chk({tag, ".busy_cyc"}, r.busy_cyc,   e.busy_cyc);
    chk({tag, ".cmd_err"},  r.err,        e.err);
    chk({tag, ".cmd_abort"},r.abort,      e.abort);
    chk({tag, ".dir"},      r.dir,        e.dir);
    chk({tag, ".rotor"},    r.st,         e.st);
    chk({tag, ".ready_busy"}, r.ready_viol, 0);
  endtask

  // Reference model: outcome of one command from the segment rules alone
  task automatic model(input logic [7:0] code, input int stop_c, inout int pos,
                       inout int mdir, output res_t e);
    int seg, total, p0;
    e = '{default: 0};
    case (code)
      8'hF7:        seg = -2;
      8'hF6:        seg = -1;
      8'hF5:        seg = 1;
      8'hF4, 8'h00: seg = 0;
      default: begin seg = 0; e.err = 1; end
    endcase
    p0 = DSETUP + 1;  // first cycle of the pulse train
    if (seg == 0) begin
      e.done_k = 1;
    end else begin
      mdir  = (seg > 0) ? 1 : 0;
      total = ((seg < 0) ? -seg : seg) * STEPS;
      if (stop_c >= 1 && stop_c < p0) begin
        e.pulses = 0;
        e.abort  = 1;
        e.done_k = stop_c + 1;
      end else begin
        if (stop_c >= p0 && stop_c < p0 + PERIOD * total) begin
          e.pulses = (stop_c - p0) / PERIOD + 1;
          if (e.pulses > total) e.pulses = total;
        end else begin
          e.pulses = total;
        end
        e.abort  = (e.pulses < total) ? 1 : 0;
        e.done_k = p0 + PERIOD * e.pulses;
      end
      pos = (pos + 8 + ((seg > 0) ? 1 : -1) * (e.pulses / STEPS)) % 8;
    end
    e.hi_cyc   = e.pulses * HIGH;
    e.busy_cyc = e.done_k;
    e.dir      = mdir;
    e.st       = 192 + pos;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_cmd(input logic [7:0] code, input int stop_c, output res_t r);
    int   w;
    logic prev;
    r = '{default: 0};
    r.done_k = -1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_angle = code;
    prev      = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_angle = 8'($urandom_range(0, 255));
      end
      if (step && !prev) r.pulses++;
      if (step) r.hi_cyc++;
      prev = step;
      if (busy) r.busy_cyc++;
      if (busy && cmd_ready) r.ready_viol++;
      if (done) begin
        r.done_k = k;
        r.err    = int'(cmd_err);
        r.abort  = int'(cmd_abort);
        r.dir    = int'(dir);
        r.st     = int'(rotor_state);
        break;
      end
      if (stop_c != 0 && k >= stop_c) stop_req = 1'b1;
    end
    stop_req = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    res_t r, e;
    int   m_pos, m_dir, nrdy, ndone, novl, w, sc;
    logic [7:0] code;

    tbl[0]  = '{8'hF5, 0,  2, 12, 0, 0, 8'hC1, 1};
    tbl[1]  = '{8'hF6, 0,  2, 12, 0, 0, 8'hC0, 0};
    tbl[2]  = '{8'hF7, 0,  4, 22, 0, 0, 8'hC6, 0};
    tbl[3]  = '{8'hF4, 0,  0, 1,  0, 0, 8'hC6, 0};
    tbl[4]  = '{8'h3C, 0,  0, 1,  1, 0, 8'hC6, 0};
    tbl[5]  = '{8'h00, 0,  0, 1,  0, 0, 8'hC6, 0};
    tbl[6]  = '{8'hFF, 0,  0, 1,  1, 0, 8'hC6, 0};
    tbl[7]  = '{8'hF6, 2,  1, 7,  0, 1, 8'hC6, 0};
    tbl[8]  = '{8'hF5, 1,  0, 2,  0, 1, 8'hC6, 1};
    tbl[9]  = '{8'hF5, 6,  1, 7,  0, 1, 8'hC6, 1};
    tbl[10] = '{8'hF7, 9,  2, 12, 0, 1, 8'hC5, 0};
    tbl[11] = '{8'hF5, 11, 2, 12, 0, 0, 8'hC6, 1};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_angle = 8'h00;
    stop_req  = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_reset.cmd_ready", int'(cmd_ready), 0);
    chk("in_reset.busy",      int'(busy),      0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset.cmd_ready", int'(cmd_ready),   1);
    chk("post_reset.rotor",     int'(rotor_state), 8'hC0);
    chk("post_reset.step",      int'(step),        0);
    chk("post_reset.dir",       int'(dir),         0);
    chk("post_reset.busy",      int'(busy),        0);
    chk("post_reset.done",      int'(done),        0);

    // Table-driven directed vectors
    foreach (tbl[i]) begin
      run_cmd(tbl[i].code, tbl[i].stop_c, r);
      e = '{default: 0};
      e.pulses   = tbl[i].pulses;
      e.done_k   = tbl[i].done_k;
      e.hi_cyc   = tbl[i].pulses * HIGH;
      e.busy_cyc = tbl[i].done_k;
      e.err      = tbl[i].err;
      e.abort    = tbl[i].abort;
      e.dir      = tbl[i].dir;
      e.st       = tbl[i].st;
      check_res($sformatf("tbl%0d", i), r, e);
    end

    // Reset in the middle of a step pulse
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    cmd_valid = 1'b1;
    cmd_angle = 8'hF5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst.step_before", int'(step), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.step",  int'(step),        0);
    chk("midrst.busy",  int'(busy),        0);
    chk("midrst.done",  int'(done),        0);
    chk("midrst.dir",   int'(dir),         0);
    chk("midrst.rotor", int'(rotor_state), 8'hC0);
    chk("midrst.ready_in_reset", int'(cmd_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.ready_after", int'(cmd_ready), 1);

    // cmd_valid held high: one transfer per IDLE visit, none while busy
    cmd_angle = 8'hF5;
    cmd_valid = 1'b1;
    nrdy = 0; ndone = 0; novl = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (cmd_ready) nrdy++;
      if (done) ndone++;
      if (cmd_ready && busy) novl++;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b.ready_cycles", nrdy,  4);
    chk("b2b.dones",        ndone, 3);
    chk("b2b.ready_busy",   novl,  0);
    chk("b2b.rotor",        int'(rotor_state), 8'hC3);

    // Randomized commands against the reference model
    m_pos = 3;
    m_dir = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: code = 8'hF7;
        1: code = 8'hF6;
        2: code = 8'hF5;
        3: code = 8'hF4;
        4: code = 8'h00;
        default: code = 8'($urandom_range(0, 255));
      endcase
      sc = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25));
      model(code, sc, m_pos, m_dir, e);
      run_cmd(code, sc, r);
      check_res($sformatf("rnd%0d_%02h_s%0d", n, code, sc), r, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
